// File: rtl/sine_tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: FSM state encoding and default widths.
package sine_tone_sequencer_pkg;
   localparam int FW_DEF  = 16;
   localparam int DW_DEF  = 24;
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      WAIT_ZC = 3'd2,
      STOP    = 3'd3,
      DONE    = 3'd4
   } seq_state_t;
endpackage

// File: rtl/sine_tone_sequencer_if.sv
// Tone-table programming bus: the master writes one step (freq, duration) per strobe.
interface sine_tone_sequencer_if
   import sine_tone_sequencer_pkg::*;
#(
   parameter int AW = 3,
   parameter int FW = FW_DEF,
   parameter int DW = DW_DEF
);
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [FW-1:0] cfg_freq;
   logic [DW-1:0] cfg_dur;

   modport master (output cfg_we, cfg_addr, cfg_freq, cfg_dur);
   modport slave  (input  cfg_we, cfg_addr, cfg_freq, cfg_dur);
endinterface

// File: rtl/sine_tone_sequencer_sw_conditioner.sv
// Slide-switch conditioner: 2-flop synchroniser, optional debouncer (SW_DEBOUNCE_EN),
// and rise/fall pulses on the conditioned level.
module sw_conditioner #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic sw_q,
   output logic sw_rise,
   output logic sw_fall
);
   logic sync1, sync2, sw_prev;

   if (DEB_CYCLES < 1) begin : g_deb_check
      $error("DEB_CYCLES must be at least 1");
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

`ifdef SW_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [CW-1:0] deb_cnt;

   // Any disagreement with the held level must persist DEB_CYCLES cycles; a bounce restarts it.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_q    <= 1'b0;
         deb_cnt <= '0;
      end else if (sync2 == sw_q) begin
         deb_cnt <= '0;
      end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
         sw_q    <= sync2;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end
`else
   assign sw_q = sync2;
`endif

   always_ff @(posedge clk) begin
      if (reset) sw_prev <= 1'b0;
      else       sw_prev <= sw_q;
   end

   assign sw_rise = sw_q & ~sw_prev;
   assign sw_fall = ~sw_q & sw_prev;
endmodule

// File: rtl/sine_tone_sequencer.sv
// Plays a programmable tone table into the sinewave generator, switching tones only at
// generator zero crossings. Optional switch debouncing is enabled by SW_DEBOUNCE_EN.
module sine_tone_sequencer
   import sine_tone_sequencer_pkg::*;
#(
   parameter int  N_STEPS    = 8,
   parameter int  FW         = FW_DEF,
   parameter int  DW         = DW_DEF,
   parameter int  DEB_CYCLES = 1000000,
   localparam int AW         = $clog2(N_STEPS)
) (
   input  logic                        sysclk,
   input  logic                        reset,
   input  logic                        Enable_SW_0,
   sine_tone_sequencer_if.slave        cfg,
   input  logic                        zero_cross,
   output logic                        gen_enable,
   output logic [FW-1:0]               gen_phase_inc,
   output logic [AW-1:0]               step_idx,
   output logic                        busy,
   output logic                        done
);
   logic [FW-1:0] freq_mem [N_STEPS];
   logic [DW-1:0] dur_mem  [N_STEPS];

   seq_state_t    state, state_d;
   logic [DW-1:0] cnt, cnt_d;
   logic [AW-1:0] step_idx_d, next_idx;
   logic [FW-1:0] phase_d;
   logic          gen_enable_d, done_d;
   logic          sw_q, sw_rise, sw_fall;
   logic          expire, can_switch, end_seq, advance;

   sw_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_sw (
      .clk     (sysclk),
      .reset   (reset),
      .sw_raw  (Enable_SW_0),
      .sw_q    (sw_q),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
   );

   // Table is only writable while idle and not on the edge that starts playback.
   always_ff @(posedge sysclk) begin
      if (!reset && cfg.cfg_we && state == IDLE && !sw_rise) begin
         freq_mem[cfg.cfg_addr] <= cfg.cfg_freq;
         dur_mem[cfg.cfg_addr]  <= cfg.cfg_dur;
      end
   end

   assign next_idx   = step_idx + 1'b1;
   assign expire     = (cnt == dur_mem[step_idx] - 1'b1);
   // A silent step has no zero crossings to wait for.
   assign can_switch = zero_cross || (gen_phase_inc == '0);
   assign end_seq    = (step_idx == AW'(N_STEPS - 1)) || (dur_mem[next_idx] == '0);
   assign busy       = (state != IDLE);

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         step_idx      <= '0;
         gen_enable    <= 1'b0;
         gen_phase_inc <= '0;
         done          <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         step_idx      <= step_idx_d;
         gen_enable    <= gen_enable_d;
         gen_phase_inc <= phase_d;
         done          <= done_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (sw_rise) state_d = (dur_mem[0] == '0) ? DONE : RUN;
         RUN: begin
            if (sw_fall)     state_d = STOP;
            else if (expire) state_d = !can_switch ? WAIT_ZC : (end_seq ? DONE : RUN);
         end
         WAIT_ZC: begin
            if (sw_fall)         state_d = STOP;
            else if (can_switch) state_d = end_seq ? DONE : RUN;
         end
         STOP:    if (can_switch) state_d = IDLE;
         DONE:    if (!sw_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d        = cnt;
      step_idx_d   = step_idx;
      gen_enable_d = gen_enable;
      phase_d      = gen_phase_inc;
      done_d       = 1'b0;
      advance      = (state_d == RUN) && ((state == WAIT_ZC) || (state == RUN && expire));
      unique case (state)
         IDLE: if (state_d == RUN) begin
            step_idx_d   = '0;
            phase_d      = freq_mem[0];
            gen_enable_d = 1'b1;
            cnt_d        = '0;
         end
         RUN, WAIT_ZC: begin
            if (state == RUN) cnt_d = cnt + 1'b1;
            if (advance) begin
               step_idx_d = next_idx;
               phase_d    = freq_mem[next_idx];
               cnt_d      = '0;
            end
         end
         STOP: if (state_d == IDLE) begin
            gen_enable_d = 1'b0;
            phase_d      = '0;
            step_idx_d   = '0;
         end
         default: ;
      endcase
      if (state_d == DONE && state != DONE) begin
         gen_enable_d = 1'b0;
         phase_d      = '0;
         done_d       = 1'b1;
      end
   end
endmodule

// File: tb/tb_sine_tone_sequencer.sv
// Directed bench for sine_tone_sequencer; latencies follow SW_DEBOUNCE_EN (DEB_CYCLES=10).
module tb_sine_tone_sequencer;
   localparam int N_STEPS = 8;
   localparam int FW      = 16;
   localparam int DW      = 24;
   localparam int AW      = 3;
   localparam int DEB     = 10;
`ifdef SW_DEBOUNCE_EN
   localparam int LAT         = 12;  // edges from the first sampling edge to the playback load
   localparam int STOP_IDLE_R = 35;
`else
   localparam int LAT         = 2;
   localparam int STOP_IDLE_R = 28;
`endif

   logic          sysclk = 1'b0;
   logic          reset, sw, zero_cross;
   logic          gen_enable, busy, done;
   logic [FW-1:0] gen_phase_inc;
   logic [AW-1:0] step_idx;
   int            n_checks = 0, n_fail = 0;
   int            rel = 0, zc_period = 0;

   sine_tone_sequencer_if #(.AW(AW), .FW(FW), .DW(DW)) cfg ();

   sine_tone_sequencer #(.N_STEPS(N_STEPS), .FW(FW), .DW(DW), .DEB_CYCLES(DEB)) dut (
      .sysclk        (sysclk),
      .reset         (reset),
      .Enable_SW_0   (sw),
      .cfg           (cfg.slave),
      .zero_cross    (zero_cross),
      .gen_enable    (gen_enable),
      .gen_phase_inc (gen_phase_inc),
      .step_idx      (step_idx),
      .busy          (busy),
      .done          (done)
   );

   always #5 sysclk = ~sysclk;

   // zero_cross is sampled high on edges where rel is a multiple of zc_period.
   task automatic tick();
      @(posedge sysclk);
      #1;
      rel++;
      zero_cross = (zc_period != 0) && (((rel + 1) % zc_period) == 0);
   endtask

   task automatic write_step(input int addr, input int freq, input int dur);
      cfg.cfg_we   = 1'b1;
      cfg.cfg_addr = AW'(addr);
      cfg.cfg_freq = FW'(freq);
      cfg.cfg_dur  = DW'(dur);
      tick();
      cfg.cfg_we   = 1'b0;
   endtask

   task automatic wait_load(input string name);
      int n = 0;
      while (gen_enable !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      n_checks++;
      if (n != LAT + 1) begin
         n_fail++;
         $display("FAIL %s_load_latency: got %0d cycles, expected %0d", name, n, LAT + 1);
      end
      rel = 0;
      zero_cross = (zc_period != 0) && ((1 % zc_period) == 0);
   endtask

   task automatic release_sw(input string name, output int dones);
      int n = 0;
      dones = 0;
      sw = 1'b0;
      while (busy !== 1'b0 && n < 60) begin
         tick();
         n++;
         if (done === 1'b1) dones++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_release_idle: busy=%b after %0d cycles, expected 0", name, busy, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({gen_enable, gen_phase_inc, step_idx, busy, done} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: en=%b inc=%0d idx=%0d busy=%b done=%b, expected all 0",
                  gen_enable, gen_phase_inc, step_idx, busy, done);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic_play();
      int d;
      write_step(0, 100, 50);
      write_step(1, 200, 30);
      write_step(2, 0, 0);
      zc_period = 7;
      sw = 1'b1;
      wait_load("t1");
      n_checks++;
      if (gen_phase_inc !== 16'd100 || step_idx !== 3'd0) begin
         n_fail++;
         $display("FAIL t1_step0: inc=%0d idx=%0d, expected 100/0", gen_phase_inc, step_idx);
      end
      // Step 0 expires at 50 (no zc), next zc at 56; step 1 expires at 86, next zc at 91.
      for (int r = 1; r <= 92; r++) begin
         tick();
         if (r == 55) begin
            n_checks++;
            if (gen_phase_inc !== 16'd100 || !busy) begin
               n_fail++;
               $display("FAIL t1_wait_zc: inc=%0d busy=%b, expected 100/1", gen_phase_inc, busy);
            end
         end
         if (r == 56) begin
            n_checks++;
            if (gen_phase_inc !== 16'd200 || step_idx !== 3'd1) begin
               n_fail++;
               $display("FAIL t1_step1: inc=%0d idx=%0d, expected 200/1", gen_phase_inc, step_idx);
            end
         end
         if (r == 90) begin
            n_checks++;
            if (gen_enable !== 1'b1 || done !== 1'b0) begin
               n_fail++;
               $display("FAIL t1_before_done: en=%b done=%b, expected 1/0", gen_enable, done);
            end
         end
         if (r == 91) begin
            n_checks++;
            if (done !== 1'b1 || gen_enable !== 1'b0 || gen_phase_inc !== 16'd0) begin
               n_fail++;
               $display("FAIL t1_done: done=%b en=%b inc=%0d, expected 1/0/0", done, gen_enable, gen_phase_inc);
            end
         end
         if (r == 92) begin
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL t1_done_pulse: done=%b busy=%b, expected 0/1", done, busy);
            end
         end
      end
      release_sw("t1", d);
   endtask

   task automatic test_stop();
      int dones = 0, d;
      zc_period = 7;
      sw = 1'b1;
      wait_load("t2");
      for (int r = 1; r <= STOP_IDLE_R + 5; r++) begin
         tick();
         if (done === 1'b1) dones++;
         if (r == 20) sw = 1'b0;
         if (r == STOP_IDLE_R - 1) begin
            n_checks++;
            if (gen_enable !== 1'b1 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL t2_stop_holds: en=%b busy=%b, expected 1/1", gen_enable, busy);
            end
         end
         if (r == STOP_IDLE_R) begin
            n_checks++;
            if ({gen_enable, busy, step_idx} !== '0) begin
               n_fail++;
               $display("FAIL t2_stop_idle: en=%b busy=%b idx=%0d, expected 0/0/0", gen_enable, busy, step_idx);
            end
         end
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL t2_no_done: got %0d done pulses, expected 0", dones);
      end
      release_sw("t2", d);
   endtask

   task automatic test_silent_step();
      int d;
      zc_period = 0;
      zero_cross = 1'b0;
      write_step(0, 0, 5);
      write_step(1, 0, 3);
      write_step(2, 0, 0);
      sw = 1'b1;
      wait_load("t3");
      for (int r = 1; r <= 8; r++) begin
         tick();
         if (r == 4 || r == 5) begin
            n_checks++;
            if (step_idx !== AW'(r - 4)) begin
               n_fail++;
               $display("FAIL t3_advance_r%0d: idx=%0d, expected %0d", r, step_idx, r - 4);
            end
         end
         if (r == 7 || r == 8) begin
            n_checks++;
            if (done !== (r == 8)) begin
               n_fail++;
               $display("FAIL t3_done_r%0d: done=%b, expected %b", r, done, r == 8);
            end
         end
      end
      release_sw("t3", d);
   endtask

   task automatic test_full_table();
      int d, dones;
      zc_period = 1;
      for (int i = 0; i < N_STEPS; i++) write_step(i, i + 1, 4);
      sw = 1'b1;
      wait_load("t4");
      for (int r = 0; r <= 40; r++) begin
         if (r > 0) tick();
         if (r % 4 == 0 && r < 32) begin
            n_checks++;
            if (step_idx !== AW'(r / 4) || gen_phase_inc !== FW'(r / 4 + 1)) begin
               n_fail++;
               $display("FAIL t4_step%0d: idx=%0d inc=%0d, expected %0d/%0d",
                        r / 4, step_idx, gen_phase_inc, r / 4, r / 4 + 1);
            end
         end
         if (r == 32) begin
            n_checks++;
            if (done !== 1'b1 || gen_enable !== 1'b0) begin
               n_fail++;
               $display("FAIL t4_table_end: done=%b en=%b, expected 1/0", done, gen_enable);
            end
         end
         if (r == 40) begin
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL t4_hold_done: done=%b busy=%b, expected 0/1", done, busy);
            end
         end
      end
      release_sw("t4", dones);
      n_checks++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL t4_release_done: got %0d done pulses, expected 0", dones);
      end
      sw = 1'b1;
      wait_load("t4_replay");
      dones = 0;
      for (int r = 1; r <= 32; r++) begin
         tick();
         if (r < 32 && done === 1'b1) dones++;
      end
      n_checks++;
      if (dones != 0 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL t4_replay_done: early=%0d done=%b, expected 0/1", dones, done);
      end
      release_sw("t4b", d);
   endtask

   task automatic test_cfg_lock_and_reset();
      int d;
      zc_period = 1;
      write_step(0, 20, 10);
      write_step(1, 30, 4);
      write_step(2, 0, 0);
      sw = 1'b1;
      repeat (LAT) tick();
      // This write lands on the edge that starts playback and must be dropped.
      write_step(2, 55, 6);
      n_checks++;
      if (gen_enable !== 1'b1) begin
         n_fail++;
         $display("FAIL t5_load: en=%b, expected 1", gen_enable);
      end
      rel = 0;
      for (int r = 1; r <= 14; r++) begin
         if (r == 3) write_step(1, 77, 0);
         else tick();
         if (r == 10) begin
            n_checks++;
            if (step_idx !== 3'd1 || gen_phase_inc !== 16'd30) begin
               n_fail++;
               $display("FAIL t5_run_write: idx=%0d inc=%0d, expected 1/30", step_idx, gen_phase_inc);
            end
         end
         if (r == 14) begin
            n_checks++;
            if (done !== 1'b1) begin
               n_fail++;
               $display("FAIL t5_load_write: done=%b, expected 1", done);
            end
         end
      end
      release_sw("t5", d);
      sw = 1'b1;
      wait_load("t5_reset");
      repeat (12) tick();
      reset = 1'b1;
      sw = 1'b0;
      tick();
      n_checks++;
      if ({gen_enable, gen_phase_inc, step_idx, busy, done} !== '0) begin
         n_fail++;
         $display("FAIL t5_mid_reset: en=%b inc=%0d idx=%0d busy=%b done=%b, expected all 0",
                  gen_enable, gen_phase_inc, step_idx, busy, done);
      end
      reset = 1'b0;
      repeat (LAT + 3) tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL t5_after_reset: busy=%b, expected 0", busy);
      end
   endtask

`ifdef SW_DEBOUNCE_EN
   task automatic test_glitch();
      int hits = 0, d;
      zc_period = 1;
      sw = 1'b1;
      repeat (3) tick();
      sw = 1'b0;
      for (int r = 0; r < 30; r++) begin
         tick();
         if (gen_enable === 1'b1 || busy === 1'b1) hits++;
      end
      n_checks++;
      if (hits != 0) begin
         n_fail++;
         $display("FAIL t6_glitch: %0d active cycles, expected 0", hits);
      end
      sw = 1'b1;
      wait_load("t6_stable");
      release_sw("t6", d);
   endtask
`endif

   initial begin
      reset        = 1'b1;
      sw           = 1'b0;
      zero_cross   = 1'b0;
      cfg.cfg_we   = 1'b0;
      cfg.cfg_addr = '0;
      cfg.cfg_freq = '0;
      cfg.cfg_dur  = '0;
      test_reset();
      test_basic_play();
      test_stop();
      test_silent_step();
      test_full_table();
      test_cfg_lock_and_reset();
`ifdef SW_DEBOUNCE_EN
      test_glitch();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
